// File: rtl/avg_unpool_2x2_pkg.sv
// Shared constants and types for the 2x2 nearest-neighbour unpooler.
// The optional divide-by-4 path is selected by the AVG_UNPOOL_SCALE_EN macro.
package avg_unpool_2x2_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned FM_IN_DIM  = 14;
   localparam int unsigned FM_OUT_DIM = 28;
   localparam int unsigned POOL_K     = 2;

   typedef logic signed [DATA_W_DEF-1:0] pixel_t;

   // Counter/address width for a range of n values (never below 1 bit)
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/avg_unpool_2x2_if.sv
// Input and output pixel streams of the unpooler, bundled as one interface.
interface avg_unpool_2x2_if
   import avg_unpool_2x2_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_eol;
   logic              out_eof;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_eol, out_eof
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_eol, out_eof
   );
endinterface

// File: rtl/avg_unpool_linebuf.sv
// One-row pixel store: written on even output rows, read back for odd rows.
module avg_unpool_linebuf
   import avg_unpool_2x2_pkg::*;
#(
   parameter  int unsigned DATA_W = DATA_W_DEF,
   parameter  int unsigned DEPTH  = FM_IN_DIM,
   localparam int unsigned AW     = cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/avg_unpool_2x2.sv
// Streaming 2x2 nearest-neighbour unpooler: each input pixel fills its 2x2 output window.
// Build option AVG_UNPOOL_SCALE_EN divides every pixel by 4 (arithmetic shift).
module avg_unpool_2x2
   import avg_unpool_2x2_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned IN_W   = FM_IN_DIM,
   parameter int unsigned IN_H   = FM_IN_DIM
) (
   input logic             clk,
   input logic             rst,
   avg_unpool_2x2_if.slave bus
);

   localparam int unsigned OUT_W = POOL_K * IN_W;
   localparam int unsigned OUT_H = POOL_K * IN_H;
   localparam int unsigned COL_W = cnt_w(OUT_W);
   localparam int unsigned ROW_W = cnt_w(OUT_H);
   localparam int unsigned AW    = cnt_w(IN_W);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);

   logic [DATA_W-1:0] data_q, data_n;
   logic              valid_q, valid_n;
   logic              rep_q, rep_n;
   logic [COL_W-1:0]  col_q, col_n;
   logic [ROW_W-1:0]  row_q, row_n;

   logic              hs, slot, load, ld_odd, in_ready_c;
   logic [AW-1:0]     lb_addr;
   logic [DATA_W-1:0] in_pix, lb_rdata;

`ifdef AVG_UNPOOL_SCALE_EN
   assign in_pix = DATA_W'($signed(bus.in_data) >>> 2);
`else
   assign in_pix = bus.in_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         rep_q   <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         data_q  <= data_n;
         valid_q <= valid_n;
         rep_q   <= rep_n;
         col_q   <= col_n;
         row_q   <= row_n;
      end
   end

   // Position counters and two-copy replication; the loaded beat sits at the post-handshake position
   always_comb begin
      data_n  = data_q;
      valid_n = valid_q;
      rep_n   = rep_q;
      col_n   = col_q;
      row_n   = row_q;

      hs   = valid_q & bus.out_ready;
      slot = ~valid_q | (bus.out_ready & rep_q);

      if (hs) begin
         if (col_q == COL_LAST) begin
            col_n = '0;
            row_n = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
         end else begin
            col_n = col_q + COL_W'(1);
         end
      end

      ld_odd     = row_n[0];
      lb_addr    = AW'(col_n >> 1);
      in_ready_c = slot & ~ld_odd & ~rst;
      load       = slot & (ld_odd | bus.in_valid) & ~rst;

      if (hs) begin
         if (rep_q) begin
            rep_n   = 1'b0;
            valid_n = 1'b0;
         end else begin
            rep_n   = 1'b1;
         end
      end

      if (load) begin
         data_n  = ld_odd ? lb_rdata : in_pix;
         valid_n = 1'b1;
         rep_n   = 1'b0;
      end
   end

   avg_unpool_linebuf #(
      .DATA_W (DATA_W),
      .DEPTH  (IN_W)
   ) u_linebuf (
      .clk   (clk),
      .we    (in_ready_c & bus.in_valid),
      .waddr (lb_addr),
      .wdata (in_pix),
      .raddr (lb_addr),
      .rdata (lb_rdata)
   );

   assign bus.in_ready  = in_ready_c;
   assign bus.out_data  = data_q;
   assign bus.out_valid = valid_q;
   assign bus.out_eol   = valid_q & (col_q == COL_LAST);
   assign bus.out_eof   = valid_q & (col_q == COL_LAST) & (row_q == ROW_LAST);

endmodule
